bcd_decoder: RTL and testbench
==============================

Name: bcd_decoder

Overview:
Sequential BCD-to-binary converter, the inverse of bcd_encoder. It takes packed BCD digits, most significant digit first, and produces the binary value. It processes one digit per clock using acc = acc*10 + digit, built from shifts and adds with no multiplier. It sits on the display/keypad input path and returns the binary value that bcd_encoder expects as its input.

Parameters:
DIGITS, 4, number of BCD digits in i_bcd; must be >= 1.
BIN_W, 16, width of o_binary; must satisfy 2^BIN_W > 10^DIGITS - 1 (16 >= 14 for the default).

Ports:
i_clk  input  1  clock; all logic on the rising edge.
i_rst  input  1  synchronous, active-high reset.
i_begin_conv  input  1  start request; level-sampled only in IDLE.
i_bcd  input  4*DIGITS  packed BCD; digit 0 in [3:0], most significant digit in [4*DIGITS-1:4*DIGITS-4].
o_busy  output  1  high while in CONV.
o_conv_done  output  1  one-cycle pulse when o_binary/o_invalid update.
o_binary  output  BIN_W  converted value; held until the next completion.
o_invalid  output  1  high if any latched nibble > 9; updates together with o_binary.

Behaviour:
- One clock (i_clk). Reset is synchronous, active-high (i_rst).
- Reset values: o_binary=0, o_invalid=0, o_conv_done=0, o_busy=0, state=IDLE, accumulator=0, digit counter=0.
- Reset has priority over all other activity. Reset mid-conversion aborts the conversion, returns the block to IDLE and clears all outputs. No done pulse is produced for the aborted conversion.
- States: IDLE, CONV.
- IDLE -> CONV: on an edge where i_begin_conv=1.
  - Latch i_bcd into the shift register.
  - acc<=0, cnt<=0, o_busy<=1, invalid flag<=0.
- CONV, each edge:
  - d = top nibble of the shift register.
  - acc <= (acc<<3) + (acc<<1) + d, computed in BIN_W bits.
  - Shift register moves left by 4.
  - flag <= flag | (d > 9).
  - cnt <= cnt+1.
- CONV, final edge (cnt == DIGITS-1):
  - o_binary <= final acc value; o_invalid <= final flag value.
  - o_conv_done <= 1 for exactly one cycle.
  - o_busy <= 0; next state IDLE.
- Latency: begin sampled at edge N; o_conv_done is high in the cycle following edge N+DIGITS (N+4 by default). o_busy is high for exactly DIGITS cycles.
- i_begin_conv and i_bcd are ignored during CONV. Changing i_bcd mid-conversion has no effect on the result.
- Back-to-back operation: if i_begin_conv is still 1 in IDLE (including the cycle where o_conv_done=1), a new conversion starts on that edge. A held-high begin therefore gives a done pulse every DIGITS+1 cycles.
- Invalid nibbles (A-F) are not clamped. They enter the arithmetic as their raw value (10-15) and the result is flagged through o_invalid.
- Overflow cannot occur when the BIN_W constraint is met. If the constraint is violated, the result wraps modulo 2^BIN_W; this case is not checked.
- o_conv_done is registered, never combinational, and is 0 in every cycle except the completion cycle.

Test Plan:
- Reset, then i_bcd=16'h0218 with i_begin_conv pulsed for one cycle at edge N -> o_busy high for 4 cycles; o_conv_done=1 only after edge N+4; o_binary=16'd218; o_invalid=0.
- i_bcd=16'h9999 -> o_binary=16'd9999 (16'h270F), o_invalid=0. Then i_bcd=16'h0000 -> o_binary=0, done pulse present.
- i_bcd=16'h1A00 -> o_binary=16'd2000 (1*1000 + 10*100), o_invalid=1. The next conversion of 16'h0042 -> o_binary=42, o_invalid=0.
- i_begin_conv held at 1 with i_bcd=16'h0218 (the encoder bench's stimulus) -> done pulses every 5 cycles, o_binary=218 each time. Changing i_bcd to 16'h1234 during CONV affects only the next conversion (result 1234).
- i_rst asserted for one cycle at cnt=2 of a 16'h9999 conversion -> next cycle all outputs 0, state IDLE, no done pulse. A fresh start then yields 9999 normally.
- Round trip: drive 16'd218, 16'd0 and 16'd9999 through bcd_encoder and feed its o_bcd into bcd_decoder -> o_binary equals the original input; o_invalid=0.

Source files
------------

// File: rtl/bcd_decoder.sv
`default_nettype none
// ============================================================================
// bcd_decoder : sequential BCD-to-binary converter, one digit per clock
// Rev 1.0
// ============================================================================
module bcd_decoder #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_begin_conv,
  input  logic [4*DIGITS-1:0]   i_bcd,
  output logic                  o_busy,
  output logic                  o_conv_done,
  output logic [BIN_W-1:0]      o_binary,
  output logic                  o_invalid
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIGITS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t                state_q,   state_d;
  logic [4*DIGITS-1:0]   sreg_q,    sreg_d;
  logic [BIN_W-1:0]      acc_q,     acc_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic                  flag_q,    flag_d;
  logic                  busy_q,    busy_d;
  logic                  done_q,    done_d;
  logic [BIN_W-1:0]      binary_q,  binary_d;
  logic                  invalid_q, invalid_d;

  logic [3:0]            digit;
  logic [BIN_W-1:0]      acc_next;
  logic                  digit_bad;

  // acc*10 + d as (acc<<3) + (acc<<1) + d; nibbles A-F enter unclamped
  assign digit     = sreg_q[4*DIGITS-1 -: 4];
  assign digit_bad = (digit > 4'd9);
  assign acc_next  = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit);

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    flag_d    = flag_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    binary_d  = binary_q;
    invalid_d = invalid_q;

    case (state_q)
      IDLE: begin
        if (i_begin_conv) begin
          sreg_d  = i_bcd;
          acc_d   = '0;
          cnt_d   = '0;
          flag_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        acc_d  = acc_next;
        sreg_d = sreg_q << 4;
        flag_d = flag_q | digit_bad;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST) begin
          binary_d  = acc_next;
          invalid_d = flag_q | digit_bad;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          cnt_d     = '0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      flag_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      binary_q  <= '0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      flag_q    <= flag_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      binary_q  <= binary_d;
      invalid_q <= invalid_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_conv_done = done_q;
  assign o_binary    = binary_q;
  assign o_invalid   = invalid_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_decoder.sv
`default_nettype none
// ============================================================================
// tb_bcd_decoder : scoreboard bench for bcd_decoder
// Rev 1.0
// ============================================================================
module tb_bcd_decoder;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              begin_conv;
  logic [15:0]       bcd;
  logic              busy;
  logic              done;
  logic [BIN_W-1:0]  binary;
  logic              invalid;

  bcd_decoder #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_begin_conv (begin_conv),
    .i_bcd        (bcd),
    .o_busy       (busy),
    .o_conv_done  (done),
    .o_binary     (binary),
    .o_invalid    (invalid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] bin;
    logic        inv;
  } exp_t;

  typedef struct {
    logic [15:0] bcd;
    logic [15:0] bin;
    logic        inv;
  } vec_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_done_cyc = -1;
  int   busy_cnt = 0;
  bit   chk_period = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] bin2bcd(input int n);
    logic [15:0] r;
    int          v;
    v = n;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Output monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_cnt++;
    if (done) begin
      if (chk_period && last_done_cyc >= 0)
        check("done_period", cyc - last_done_cyc, DIGITS + 1);
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("binary", int'(binary), int'(e.bin));
        check("invalid", int'(invalid), int'(e.inv));
      end
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic run_one(input logic [15:0] v, input logic [15:0] b, input logic inv);
    exp_t e;
    @(negedge clk);
    bcd        = v;
    begin_conv = 1'b1;
    e.bin = b;
    e.inv = inv;
    exp_q.push_back(e);
    @(posedge clk);
    #1 begin_conv = 1'b0;
    wait_drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[9];
    exp_t e;
    int   start_cyc;
    int   n;

    vecs[0] = '{16'h9999, 16'd9999,  1'b0};
    vecs[1] = '{16'h0000, 16'd0,     1'b0};
    vecs[2] = '{16'h1A00, 16'd2000,  1'b1};
    vecs[3] = '{16'h0042, 16'd42,    1'b0};
    vecs[4] = '{16'h0001, 16'd1,     1'b0};
    vecs[5] = '{16'h1000, 16'd1000,  1'b0};
    vecs[6] = '{16'hF000, 16'd15000, 1'b1};
    vecs[7] = '{16'h00F0, 16'd150,   1'b1};
    vecs[8] = '{16'h8765, 16'd8765,  1'b0};

    rst        = 1'b1;
    begin_conv = 1'b0;
    bcd        = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_binary", int'(binary), 0);
    check("reset_invalid", int'(invalid), 0);

    // First conversion: latency and busy width
    @(negedge clk);
    bcd        = 16'h0218;
    begin_conv = 1'b1;
    e.bin = 16'd218;
    e.inv = 1'b0;
    exp_q.push_back(e);
    busy_cnt = 0;
    @(posedge clk);
    #1 begin_conv = 1'b0;
    start_cyc = cyc;
    wait_drain();
    check("done_latency", last_done_cyc - start_cyc, DIGITS);
    check("busy_cycles", busy_cnt, DIGITS);

    foreach (vecs[i]) run_one(vecs[i].bcd, vecs[i].bin, vecs[i].inv);

    // Held begin: back-to-back conversions, input change mid-conversion
    @(negedge clk);
    bcd           = 16'h0218;
    begin_conv    = 1'b1;
    chk_period    = 1'b1;
    last_done_cyc = -1;
    for (int k = 0; k < 3; k++) begin
      e.bin = 16'd218;
      e.inv = 1'b0;
      exp_q.push_back(e);
      repeat (5) @(posedge clk);
    end
    e.bin = 16'd218;
    exp_q.push_back(e);
    repeat (3) @(posedge clk);
    #1 bcd = 16'h1234;
    repeat (2) @(posedge clk);
    e.bin = 16'd1234;
    exp_q.push_back(e);
    repeat (5) @(posedge clk);
    #1 begin_conv = 1'b0;
    wait_drain();
    chk_period = 1'b0;

    // Reset at cnt=2 aborts a conversion without a done pulse
    @(negedge clk);
    bcd        = 16'h9999;
    begin_conv = 1'b1;
    @(posedge clk);
    #1 begin_conv = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_binary", int'(binary), 0);
    check("abort_invalid", int'(invalid), 0);
    repeat (8) @(negedge clk);
    run_one(16'h9999, 16'd9999, 1'b0);

    // Round trip through a BCD encoding
    run_one(bin2bcd(218), 16'd218, 1'b0);
    run_one(bin2bcd(0), 16'd0, 1'b0);
    run_one(bin2bcd(9999), 16'd9999, 1'b0);
    for (int k = 0; k < 8; k++) begin
      n = int'($urandom_range(0, 9999));
      run_one(bin2bcd(n), 16'(n), 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
